// File: rtl/down_counter_timer.sv
// Loadable synchronous down counter / interval timer with IDLE/RUN/DONE control FSM.
// Optional auto-reload on terminal count when DOWN_COUNTER_AUTO_RELOAD_EN is defined.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic             tc_n;
    logic             load_fire;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload, reload_n;
`endif

    assign load_ready = (state != RUN);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign load_fire  = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= ZERO;
            tc    <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload <= ZERO;
`endif
        end else begin
            state <= state_n;
            q     <= q_n;
            tc    <= tc_n;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload <= reload_n;
`endif
        end
    end

    // Priority after reset: clr, then load, then count enable.
    always_comb begin
        state_n = state;
        q_n     = q;
        tc_n    = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        reload_n = reload;
`endif
        if (clr) begin
            state_n = IDLE;
            q_n     = ZERO;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_n = ZERO;
`endif
        end else if (load_fire) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_n = load_value;
`endif
            if (load_value != ZERO) begin
                q_n     = load_value;
                state_n = RUN;
            end else begin
                q_n     = ZERO;
                tc_n    = 1'b1;
                state_n = DONE;
            end
        end else if (state == RUN && en) begin
            if (q == ONE) begin
                tc_n = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                q_n  = reload;
`else
                q_n     = ZERO;
                state_n = DONE;
`endif
            end else if (q != ZERO) begin
                q_n = q - ONE;
            end
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Table-driven self-checking bench for down_counter_timer; expected outputs flow
// through a scoreboard queue and are compared one cycle after being driven.
module tb_down_counter_timer;

    typedef struct packed {
        logic       rst;
        logic       clr;
        logic       lv;
        logic [3:0] val;
        logic       en;
        logic [3:0] eq;
        logic       etc;
        logic       ebusy;
        logic       edone;
        logic       eready;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic       load_ready;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    vec_t sb[$];

    down_counter_timer #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .en         (en),
        .clr        (clr),
        .q          (q),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic c, input logic lv,
                                input logic [3:0] v, input logic e,
                                input logic [3:0] eq, input logic etc,
                                input logic eb, input logic ed, input logic er);
        vec_t t;
        t.rst = r;  t.clr = c;  t.lv = lv;  t.val = v;  t.en = e;
        t.eq = eq;  t.etc = etc; t.ebusy = eb; t.edone = ed; t.eready = er;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t t);
        @(negedge clk);
        rst        = t.rst;
        clr        = t.clr;
        load_valid = t.lv;
        load_value = t.val;
        en         = t.en;
        sb.push_back(t);
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL vec%0d: scoreboard empty", idx);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (q !== e.eq || tc !== e.etc || busy !== e.ebusy ||
            done !== e.edone || load_ready !== e.eready) begin
            errors++;
            $display("[TB] FAIL vec%0d: got q=%0d tc=%b busy=%b done=%b ready=%b, expected q=%0d tc=%b busy=%b done=%b ready=%b",
                     idx, q, tc, busy, done, load_ready,
                     e.eq, e.etc, e.ebusy, e.edone, e.eready);
        end
    endtask

    initial begin
        //                 rst clr lv val  en    q  tc  b  d  rdy
        vecs.push_back(mk(1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1));
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
        // Reset asserted for two cycles mid-count at q=5.
        vecs.push_back(mk(0, 0, 1, 4'd5, 0, 4'd5, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'd0, 1, 4'd0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 4'd9, 1, 4'd0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, 0, 0, 0, 1));
        // Load 3 together with en: load wins, then 2,1,0.
        vecs.push_back(mk(0, 0, 1, 4'd3, 1, 4'd3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, 0, 0, 1, 1));
        // Load 4 from DONE, en pattern 1,0,0,1,1,1.
        vecs.push_back(mk(0, 0, 1, 4'd4, 0, 4'd4, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 4'd3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 4'd3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1));
        // Load of zero: immediate one-cycle tc, DONE.
        vecs.push_back(mk(0, 0, 1, 4'd0, 0, 4'd0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1));
        // load_valid during RUN is ignored.
        vecs.push_back(mk(0, 0, 1, 4'd3, 0, 4'd3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'd7, 1, 4'd2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'd7, 1, 4'd1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 1, 1));
        // clr beats load in DONE; clr beats en in RUN; en ignored in IDLE.
        vecs.push_back(mk(0, 1, 1, 4'd9, 0, 4'd0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4'd6, 0, 4'd6, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 4'd0, 0, 0, 0, 1));
        // Full-scale count from 15 with no wrap.
        vecs.push_back(mk(0, 0, 1, 4'd15, 1, 4'd15, 0, 1, 0, 0));
        for (int i = 14; i >= 1; i--)
            vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'(i), 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, 0, 0, 1, 1));
`else
        // Auto-reload: 2,1,2,1,2 with tc on each reload, never DONE.
        vecs.push_back(mk(0, 0, 1, 4'd2, 1, 4'd2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 4'd2, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1, 4'd0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, 0, 0, 0, 1));
        // Zero load still goes to DONE with a tc pulse.
        vecs.push_back(mk(0, 0, 1, 4'd0, 0, 4'd0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, 0, 0, 1, 1));
        // Reload of 1 gives tc on every enabled cycle.
        vecs.push_back(mk(0, 0, 1, 4'd1, 0, 4'd1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 4'd1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 4'd1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
